// File: rtl/mem_responder.sv
// mem_responder: in-order main-memory responder behind the arbiter's memory port.
// Requests (line read/write plus requester tag) are queued in a small FIFO.
// One request at a time is serviced. After a fixed latency a one-cycle response
// returns the line (read data, or an echo of the written line) and the echoed tag.
// The backing store has no reset, so its contents survive a reset.
module mem_responder #(
    parameter int PA_WIDTH    = 32,
    parameter int LINE_WIDTH  = 128,
    parameter int ID_WIDTH    = 2,
    parameter int MEM_LINES   = 256,
    parameter int LATENCY     = 4,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_mem_enable,
    input  logic [PA_WIDTH-1:0]   i_mem_addr,
    input  logic [LINE_WIDTH-1:0] i_mem_data,
    input  logic                  i_mem_write,
    input  logic [ID_WIDTH-1:0]   i_mem_id,
    output logic                  o_mem_full,
    output logic                  o_mem_enable,
    output logic [LINE_WIDTH-1:0] o_mem_data,
    output logic [ID_WIDTH-1:0]   o_mem_id,
    output logic                  o_overflow
);

    localparam int LINE_BYTES = LINE_WIDTH / 8;
    localparam int OFF_W      = $clog2(LINE_BYTES);
    localparam int IDX_W      = $clog2(MEM_LINES);
    localparam int PTR_W      = $clog2(QUEUE_DEPTH);
    localparam int CNT_W      = $clog2(LATENCY);

    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(QUEUE_DEPTH);
    localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    // A request popped from IDLE already spent its acceptance cycle waiting,
    // so it needs one wait cycle less than one popped straight out of RESP.
    // This keeps the single-request latency and the back-to-back spacing
    // both equal to LATENCY.
    localparam logic [CNT_W-1:0] CNT_FROM_IDLE = CNT_W'(LATENCY - 2);
    localparam logic [CNT_W-1:0] CNT_FROM_RESP = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
    localparam bit               DIRECT_RESP   = (LATENCY == 2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Backing store (no reset) and FIFO payload.
    logic [LINE_WIDTH-1:0] storage_q   [MEM_LINES];
    logic [IDX_W-1:0]      fifo_idx_q  [QUEUE_DEPTH];
    logic [LINE_WIDTH-1:0] fifo_data_q [QUEUE_DEPTH];
    logic                  fifo_write_q[QUEUE_DEPTH];
    logic [ID_WIDTH-1:0]   fifo_id_q   [QUEUE_DEPTH];

    // FIFO control.
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;
    logic             overflow_q, overflow_d;

    // Service stage.
    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [IDX_W-1:0]      svc_idx_q;
    logic [LINE_WIDTH-1:0] svc_data_q;
    logic                  svc_write_q;
    logic [ID_WIDTH-1:0]   svc_id_q;

    // Registered response outputs.
    logic                  mem_enable_q;
    logic [LINE_WIDTH-1:0] mem_data_q;
    logic [ID_WIDTH-1:0]   mem_id_q;

    // Combinational helpers.
    logic [IDX_W-1:0]      req_idx_s;
    logic                  full_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  drop_s;
    logic [IDX_W-1:0]      head_idx_s;
    logic [LINE_WIDTH-1:0] head_data_s;
    logic                  head_write_s;
    logic [ID_WIDTH-1:0]   head_id_s;
    logic [LINE_WIDTH-1:0] direct_data_s;
    logic [LINE_WIDTH-1:0] wait_data_s;
    logic                  addr_unused_s;

    // Offset bits are ignored and upper bits alias onto the same lines.
    assign req_idx_s     = i_mem_addr[OFF_W +: IDX_W];
    assign addr_unused_s = ^i_mem_addr;

    assign full_s       = (count_q == FULL_COUNT);
    assign head_idx_s   = fifo_idx_q[rd_ptr_q];
    assign head_data_s  = fifo_data_q[rd_ptr_q];
    assign head_write_s = fifo_write_q[rd_ptr_q];
    assign head_id_s    = fifo_id_q[rd_ptr_q];

    // Queue handshake: the FSM pops from IDLE or RESP. A push is taken when the
    // queue has room, or when it is full but the FSM frees a slot this same cycle.
    always_comb begin
        pop_s  = 1'b0;
        push_s = 1'b0;
        drop_s = 1'b0;
        if (((state_q == ST_IDLE) || (state_q == ST_RESP)) && (count_q != {(PTR_W + 1){1'b0}})) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        if (i_mem_enable && (!full_s || pop_s)) begin
            push_s = 1'b1;
        end else if (i_mem_enable) begin
            drop_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
    end

    // Next-state values for the FIFO pointers, occupancy and sticky overflow flag.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | drop_s;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + COUNT_ONE;
            2'b01:   count_d = count_q - COUNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Response line selection: write echoes the store line, read returns storage.
    always_comb begin
        direct_data_s = {LINE_WIDTH{1'b0}};
        wait_data_s   = {LINE_WIDTH{1'b0}};
        if (head_write_s) begin
            direct_data_s = head_data_s;
        end else begin
            direct_data_s = storage_q[head_idx_s];
        end
        if (svc_write_q) begin
            wait_data_s = svc_data_q;
        end else begin
            wait_data_s = storage_q[svc_idx_q];
        end
    end

    // FIFO control registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {(PTR_W + 1){1'b0}};
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO payload write on an accepted request.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_idx_q[wr_ptr_q]   <= req_idx_s;
            fifo_data_q[wr_ptr_q]  <= i_mem_data;
            fifo_write_q[wr_ptr_q] <= i_mem_write;
            fifo_id_q[wr_ptr_q]    <= i_mem_id;
        end
    end

    // Backing-store update at the end of a write's response cycle.
    always_ff @(posedge clk) begin
        if ((state_q == ST_RESP) && svc_write_q) begin
            storage_q[svc_idx_q] <= svc_data_q;
        end
    end

    // Service FSM with registered response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            svc_idx_q    <= {IDX_W{1'b0}};
            svc_data_q   <= {LINE_WIDTH{1'b0}};
            svc_write_q  <= 1'b0;
            svc_id_q     <= {ID_WIDTH{1'b0}};
            mem_enable_q <= 1'b0;
            mem_data_q   <= {LINE_WIDTH{1'b0}};
            mem_id_q     <= {ID_WIDTH{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE, ST_RESP: begin
                    mem_enable_q <= 1'b0;
                    if (pop_s) begin
                        svc_idx_q   <= head_idx_s;
                        svc_data_q  <= head_data_s;
                        svc_write_q <= head_write_s;
                        svc_id_q    <= head_id_s;
                        if (state_q == ST_RESP) begin
                            cnt_q   <= CNT_FROM_RESP;
                            state_q <= ST_WAIT;
                        end else if (DIRECT_RESP) begin
                            cnt_q        <= CNT_FROM_IDLE;
                            state_q      <= ST_RESP;
                            mem_enable_q <= 1'b1;
                            mem_data_q   <= direct_data_s;
                            mem_id_q     <= head_id_s;
                        end else begin
                            cnt_q   <= CNT_FROM_IDLE;
                            state_q <= ST_WAIT;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == CNT_ONE) begin
                        state_q      <= ST_RESP;
                        mem_enable_q <= 1'b1;
                        mem_data_q   <= wait_data_s;
                        mem_id_q     <= svc_id_q;
                    end else begin
                        cnt_q        <= cnt_q - CNT_ONE;
                        mem_enable_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    mem_enable_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_mem_full   = full_s;
    assign o_mem_enable = mem_enable_q;
    assign o_mem_data   = mem_data_q;
    assign o_mem_id     = mem_id_q;
    assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: single write/read, offset and alias indexing,
// queue overflow, asynchronous reset mid-service, and push while full with a pop.
`timescale 1ns/1ps
module tb_mem_responder;

    localparam int LAT = 4;
    localparam logic [127:0] D_A5 = {16{8'hA5}};
    localparam logic [127:0] D_11 = {16{8'h11}};
    localparam logic [127:0] D_22 = {16{8'h22}};
    localparam logic [127:0] D_33 = {16{8'h33}};
    localparam logic [127:0] D_44 = {16{8'h44}};

    logic         clk;
    logic         rst;
    logic         i_mem_enable;
    logic [31:0]  i_mem_addr;
    logic [127:0] i_mem_data;
    logic         i_mem_write;
    logic [1:0]   i_mem_id;
    logic         o_mem_full;
    logic         o_mem_enable;
    logic [127:0] o_mem_data;
    logic [1:0]   o_mem_id;
    logic         o_overflow;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    int           rsp_edge_q[$];
    logic [1:0]   rsp_id_q[$];
    logic [127:0] rsp_data_q[$];

    mem_responder #(
        .PA_WIDTH(32), .LINE_WIDTH(128), .ID_WIDTH(2),
        .MEM_LINES(256), .LATENCY(LAT), .QUEUE_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .i_mem_enable(i_mem_enable), .i_mem_addr(i_mem_addr), .i_mem_data(i_mem_data),
        .i_mem_write(i_mem_write), .i_mem_id(i_mem_id),
        .o_mem_full(o_mem_full), .o_mem_enable(o_mem_enable), .o_mem_data(o_mem_data),
        .o_mem_id(o_mem_id), .o_overflow(o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Response monitor: records every pulse with the index of the edge that raised it.
    always @(negedge clk) begin
        if (o_mem_enable === 1'b1) begin
            rsp_edge_q.push_back(edge_n);
            rsp_id_q.push_back(o_mem_id);
            rsp_data_q.push_back(o_mem_data);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic w, input logic [31:0] a, input logic [127:0] d, input logic [1:0] id);
        i_mem_enable = 1'b1;
        i_mem_write  = w;
        i_mem_addr   = a;
        i_mem_data   = d;
        i_mem_id     = id;
    endtask

    task automatic clr_req();
        i_mem_enable = 1'b0;
        i_mem_write  = 1'b0;
        i_mem_addr   = 32'h0;
        i_mem_data   = 128'h0;
        i_mem_id     = 2'd0;
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [127:0] d, input logic [1:0] id, output int acc);
        set_req(w, a, d, id);
        step();
        acc = edge_n;
        clr_req();
    endtask

    task automatic clear_rsp();
        rsp_edge_q.delete();
        rsp_id_q.delete();
        rsp_data_q.delete();
    endtask

    task automatic wait_rsp(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (rsp_id_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clr_req();
        step();
        step();
        checks++; if (o_mem_enable !== 1'b0) begin errors++; $display("FAIL reset_enable got %b exp 0", o_mem_enable); end
        checks++; if (o_mem_data !== 128'h0) begin errors++; $display("FAIL reset_data got %h exp 0", o_mem_data); end
        checks++; if (o_mem_id !== 2'd0) begin errors++; $display("FAIL reset_id got %0d exp 0", o_mem_id); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", o_overflow); end
        checks++; if (o_mem_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", o_mem_full); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_write_read();
        int acc;
        bit ok;
        clear_rsp();
        issue(1'b1, 32'h40, D_A5, 2'd1, acc);
        wait_rsp(1, 20, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wr_timeout got %0d responses exp 1", rsp_id_q.size()); end
        if (ok) begin
            checks++; if (rsp_edge_q[0] !== acc + LAT - 1) begin errors++; $display("FAIL wr_latency got edge %0d exp %0d", rsp_edge_q[0], acc + LAT - 1); end
            checks++; if (rsp_id_q[0] !== 2'd1) begin errors++; $display("FAIL wr_id got %0d exp 1", rsp_id_q[0]); end
            checks++; if (rsp_data_q[0] !== D_A5) begin errors++; $display("FAIL wr_data got %h exp %h", rsp_data_q[0], D_A5); end
        end
        repeat (LAT + 2) step();
        checks++; if (rsp_id_q.size() !== 1) begin errors++; $display("FAIL wr_single_pulse got %0d pulses exp 1", rsp_id_q.size()); end
        clear_rsp();
        issue(1'b0, 32'h4C, 128'h0, 2'd2, acc);
        wait_rsp(1, 20, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rd_timeout got %0d responses exp 1", rsp_id_q.size()); end
        if (ok) begin
            checks++; if (rsp_edge_q[0] !== acc + LAT - 1) begin errors++; $display("FAIL rd_latency got edge %0d exp %0d", rsp_edge_q[0], acc + LAT - 1); end
            checks++; if (rsp_id_q[0] !== 2'd2) begin errors++; $display("FAIL rd_id got %0d exp 2", rsp_id_q[0]); end
            checks++; if (rsp_data_q[0] !== D_A5) begin errors++; $display("FAIL rd_data got %h exp %h", rsp_data_q[0], D_A5); end
        end
        step();
    endtask

    task automatic test_alias();
        int acc0;
        int acc1;
        int e0;
        int e1;
        bit ok;
        clear_rsp();
        issue(1'b1, 32'h40 + 32'd256 * 32'd16, D_11, 2'd3, acc0);
        issue(1'b0, 32'h40, 128'h0, 2'd0, acc1);
        e0 = acc0 + LAT - 1;
        e1 = (acc1 + LAT - 1 > e0 + LAT) ? acc1 + LAT - 1 : e0 + LAT;
        wait_rsp(2, 30, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL alias_timeout got %0d responses exp 2", rsp_id_q.size()); end
        if (ok) begin
            checks++; if (rsp_data_q[0] !== D_11) begin errors++; $display("FAIL alias_wr_data got %h exp %h", rsp_data_q[0], D_11); end
            checks++; if (rsp_edge_q[0] !== e0) begin errors++; $display("FAIL alias_wr_edge got %0d exp %0d", rsp_edge_q[0], e0); end
            checks++; if (rsp_id_q[1] !== 2'd0) begin errors++; $display("FAIL alias_rd_id got %0d exp 0", rsp_id_q[1]); end
            checks++; if (rsp_data_q[1] !== D_11) begin errors++; $display("FAIL alias_rd_data got %h exp %h", rsp_data_q[1], D_11); end
            checks++; if (rsp_edge_q[1] !== e1) begin errors++; $display("FAIL alias_spacing got edge %0d exp %0d", rsp_edge_q[1], e1); end
        end
        step();
    endtask

    task automatic test_overflow();
        int acc[7];
        int exp_e[6];
        logic [1:0] exp_id[6];
        bit ok;
        clear_rsp();
        // Seven consecutive cycles from idle/empty: the queue fills after the sixth
        // and the seventh request (id 2) arrives while full with no pop, so it is dropped.
        for (int k = 0; k < 7; k++) begin
            set_req(1'b0, 32'h40, D_33, 2'(k % 4));
            step();
            acc[k] = edge_n;
            if (k == 5) begin
                checks++; if (o_mem_full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b exp 1", o_mem_full); end
                checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", o_overflow); end
            end
        end
        clr_req();
        checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", o_overflow); end
        for (int k = 0; k < 6; k++) begin
            exp_id[k] = 2'(k % 4);
            if (k == 0) exp_e[k] = acc[0] + LAT - 1;
            else exp_e[k] = (acc[k] + LAT - 1 > exp_e[k-1] + LAT) ? acc[k] + LAT - 1 : exp_e[k-1] + LAT;
        end
        wait_rsp(6, 60, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ovf_timeout got %0d responses exp 6", rsp_id_q.size()); end
        if (ok) begin
            for (int k = 0; k < 6; k++) begin
                checks++; if (rsp_id_q[k] !== exp_id[k]) begin errors++; $display("FAIL ovf_id[%0d] got %0d exp %0d", k, rsp_id_q[k], exp_id[k]); end
                checks++; if (rsp_edge_q[k] !== exp_e[k]) begin errors++; $display("FAIL ovf_edge[%0d] got %0d exp %0d", k, rsp_edge_q[k], exp_e[k]); end
                checks++; if (rsp_data_q[k] !== D_11) begin errors++; $display("FAIL ovf_data[%0d] got %h exp %h", k, rsp_data_q[k], D_11); end
            end
        end
        repeat (LAT + 4) step();
        checks++; if (rsp_id_q.size() !== 6) begin errors++; $display("FAIL ovf_dropped got %0d responses exp 6", rsp_id_q.size()); end
        checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", o_overflow); end
    endtask

    task automatic test_reset_mid();
        int acc;
        bit ok;
        clear_rsp();
        issue(1'b1, 32'h80, D_22, 2'd3, acc);
        wait_rsp(1, 20, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rst_pre_timeout got %0d responses exp 1", rsp_id_q.size()); end
        step();
        // One request goes into service, two more are left queued (both writes).
        set_req(1'b0, 32'h40, 128'h0, 2'd1);
        step();
        set_req(1'b1, 32'h80, D_33, 2'd2);
        step();
        set_req(1'b1, 32'h40, D_44, 2'd0);
        step();
        clr_req();
        #1;
        rst = 1'b0;
        #1;
        checks++; if (o_mem_enable !== 1'b0) begin errors++; $display("FAIL rst_mid_enable got %b exp 0", o_mem_enable); end
        checks++; if (o_mem_data !== 128'h0) begin errors++; $display("FAIL rst_mid_data got %h exp 0", o_mem_data); end
        checks++; if (o_mem_id !== 2'd0) begin errors++; $display("FAIL rst_mid_id got %0d exp 0", o_mem_id); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL rst_mid_overflow got %b exp 0", o_overflow); end
        clear_rsp();
        step();
        step();
        rst = 1'b1;
        repeat (3 * LAT + 2) step();
        checks++; if (rsp_id_q.size() !== 0) begin errors++; $display("FAIL rst_no_resp got %0d responses exp 0", rsp_id_q.size()); end
        checks++; if (o_mem_full !== 1'b0) begin errors++; $display("FAIL rst_full got %b exp 0", o_mem_full); end
        issue(1'b0, 32'h80, 128'h0, 2'd1, acc);
        issue(1'b0, 32'h40, 128'h0, 2'd2, acc);
        wait_rsp(2, 30, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rst_post_timeout got %0d responses exp 2", rsp_id_q.size()); end
        if (ok) begin
            checks++; if (rsp_data_q[0] !== D_22) begin errors++; $display("FAIL rst_keep_80 got %h exp %h", rsp_data_q[0], D_22); end
            checks++; if (rsp_data_q[1] !== D_11) begin errors++; $display("FAIL rst_keep_40 got %h exp %h", rsp_data_q[1], D_11); end
        end
        step();
    endtask

    task automatic test_full_push_pop();
        int acc[7];
        int exp_e[7];
        logic [1:0] exp_id[7];
        logic [127:0] exp_d[7];
        bit ok;
        clear_rsp();
        for (int k = 0; k < 6; k++) begin
            set_req(1'b0, 32'h80, 128'h0, 2'(k % 4));
            step();
            acc[k] = edge_n;
        end
        clr_req();
        step();
        step();
        // Queue is full and the second response is on the outputs, so the FSM pops at the next edge.
        checks++; if (o_mem_full !== 1'b1) begin errors++; $display("FAIL fpp_pre_full got %b exp 1", o_mem_full); end
        checks++; if (o_mem_enable !== 1'b1) begin errors++; $display("FAIL fpp_pre_resp got %b exp 1", o_mem_enable); end
        set_req(1'b0, 32'h40, 128'h0, 2'd2);
        step();
        acc[6] = edge_n;
        clr_req();
        checks++; if (o_mem_full !== 1'b1) begin errors++; $display("FAIL fpp_count got full %b exp 1", o_mem_full); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL fpp_overflow got %b exp 0", o_overflow); end
        for (int k = 0; k < 7; k++) begin
            exp_id[k] = (k == 6) ? 2'd2 : 2'(k % 4);
            exp_d[k]  = (k == 6) ? D_11 : D_22;
            if (k == 0) exp_e[k] = acc[0] + LAT - 1;
            else exp_e[k] = (acc[k] + LAT - 1 > exp_e[k-1] + LAT) ? acc[k] + LAT - 1 : exp_e[k-1] + LAT;
        end
        wait_rsp(7, 80, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL fpp_timeout got %0d responses exp 7", rsp_id_q.size()); end
        if (ok) begin
            for (int k = 0; k < 7; k++) begin
                checks++; if (rsp_id_q[k] !== exp_id[k]) begin errors++; $display("FAIL fpp_id[%0d] got %0d exp %0d", k, rsp_id_q[k], exp_id[k]); end
                checks++; if (rsp_edge_q[k] !== exp_e[k]) begin errors++; $display("FAIL fpp_edge[%0d] got %0d exp %0d", k, rsp_edge_q[k], exp_e[k]); end
                checks++; if (rsp_data_q[k] !== exp_d[k]) begin errors++; $display("FAIL fpp_data[%0d] got %h exp %h", k, rsp_data_q[k], exp_d[k]); end
            end
        end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL fpp_overflow_end got %b exp 0", o_overflow); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_alias();
        test_overflow();
        test_reset_mid();
        test_full_push_pop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
